// File: rtl/tick_sched.sv
// Tick generator (1 ms base, FSM enable, blink level) plus a two-requester round-robin
// one-shot timer. Define TICK_SCHED_ABORT_EN to let abort_i cancel a running timer.
module tick_sched #(
    parameter int unsigned BASE_DIV  = 50000,
    parameter int unsigned FSM_DIV   = 5,
    parameter int unsigned BLINK_DIV = 250
) (
    input  logic        clk_i,
    input  logic        rst_ni,
    output logic        tick_1ms_o,
    output logic        tick_fsm_o,
    output logic        blink_o,
    input  logic [1:0]  req_i,
    input  logic [15:0] dur0_i,
    input  logic [15:0] dur1_i,
    input  logic        abort_i,
    output logic [1:0]  gnt_o,
    output logic        busy_o,
    output logic        done_o,
    output logic        done_id_o
);

    localparam int unsigned BaseW  = (BASE_DIV > 1) ? $clog2(BASE_DIV) : 1;
    localparam int unsigned FsmW   = (FSM_DIV > 1) ? $clog2(FSM_DIV) : 1;
    localparam int unsigned BlinkW = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;

    typedef enum logic [1:0] {StIdle, StRun, StDone} state_e;

    logic [BaseW-1:0]  base_cnt_q, base_cnt_d;
    logic [FsmW-1:0]   fsm_cnt_q, fsm_cnt_d;
    logic [BlinkW-1:0] blink_cnt_q, blink_cnt_d;
    logic              blink_q, blink_d;
    logic              tick_1ms, fsm_wrap, blink_wrap;

    state_e            state_q;
    logic [15:0]       rem_q;
    logic              owner_q;
    logic              last_q;
    logic              busy_q;

    logic              grant_vld;
    logic              gnt_idx;
    logic [15:0]       dur_sel;
    logic              abort_en;

`ifdef TICK_SCHED_ABORT_EN
    assign abort_en = abort_i;
`else
    logic unused_abort;
    assign unused_abort = abort_i;
    assign abort_en     = 1'b0;
`endif

    always_comb begin
        tick_1ms    = (base_cnt_q == BaseW'(BASE_DIV - 1));
        fsm_wrap    = (fsm_cnt_q == FsmW'(FSM_DIV - 1));
        blink_wrap  = (blink_cnt_q == BlinkW'(BLINK_DIV - 1));
        base_cnt_d  = tick_1ms ? '0 : base_cnt_q + BaseW'(1);
        fsm_cnt_d   = fsm_cnt_q;
        blink_cnt_d = blink_cnt_q;
        blink_d     = blink_q;
        if (tick_1ms) begin
            fsm_cnt_d   = fsm_wrap ? '0 : fsm_cnt_q + FsmW'(1);
            blink_cnt_d = blink_wrap ? '0 : blink_cnt_q + BlinkW'(1);
            blink_d     = blink_q ^ blink_wrap;
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            base_cnt_q  <= '0;
            fsm_cnt_q   <= '0;
            blink_cnt_q <= '0;
            blink_q     <= 1'b0;
        end else begin
            base_cnt_q  <= base_cnt_d;
            fsm_cnt_q   <= fsm_cnt_d;
            blink_cnt_q <= blink_cnt_d;
            blink_q     <= blink_d;
        end
    end

    // Round-robin: on contention serve whoever was not granted last.
    always_comb begin
        gnt_idx = 1'b0;
        if (req_i == 2'b10) begin
            gnt_idx = 1'b1;
        end else if (req_i == 2'b11) begin
            gnt_idx = ~last_q;
        end
        grant_vld = rst_ni && (state_q == StIdle) && (req_i != 2'b00);
        dur_sel   = gnt_idx ? dur1_i : dur0_i;
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            state_q <= StIdle;
            rem_q   <= '0;
            owner_q <= 1'b0;
            last_q  <= 1'b1;
            busy_q  <= 1'b0;
        end else begin
            unique case (state_q)
                StIdle: begin
                    if (grant_vld) begin
                        rem_q   <= dur_sel;
                        owner_q <= gnt_idx;
                        last_q  <= gnt_idx;
                        busy_q  <= 1'b1;
                        state_q <= (dur_sel == 16'd0) ? StDone : StRun;
                    end
                end
                StRun: begin
                    // Abort takes priority over a coinciding final decrement.
                    if (abort_en) begin
                        busy_q  <= 1'b0;
                        state_q <= StIdle;
                    end else if (tick_1ms && rem_q != 16'd0) begin
                        rem_q <= rem_q - 16'd1;
                        if (rem_q == 16'd1) begin
                            state_q <= StDone;
                        end
                    end
                end
                StDone: begin
                    busy_q  <= 1'b0;
                    state_q <= StIdle;
                end
                default: state_q <= StIdle;
            endcase
        end
    end

    assign tick_1ms_o = tick_1ms;
    assign tick_fsm_o = tick_1ms & fsm_wrap;
    assign blink_o    = blink_q;
    assign gnt_o      = grant_vld ? (gnt_idx ? 2'b10 : 2'b01) : 2'b00;
    assign busy_o     = busy_q;
    assign done_o     = (state_q == StDone);
    assign done_id_o  = (state_q == StDone) & owner_q;

endmodule

// File: doc/tick_sched.md
TICK_SCHED -- requirements
Module: tick_sched

Interface
REQ-001 Parameter BASE_DIV, default 50000: clk cycles per base tick (1 ms at 50 MHz).
REQ-002 Parameter FSM_DIV, default 5: base ticks per tick_fsm (200 Hz).
REQ-003 Parameter BLINK_DIV, default 250: base ticks per blink toggle (2 Hz square).
REQ-004 clk  input  1  system clock, 50 MHz; sole clock, all logic on rising edge.
REQ-005 rst_n  input  1  reset; synchronous, active-low.
REQ-006 tick_1ms  output  1  one-cycle enable pulse every BASE_DIV cycles.
REQ-007 tick_fsm  output  1  one-cycle enable pulse for vending FSM.
REQ-008 blink  output  1  display blink level.
REQ-009 req  input  2  level timer requests; bit0 dispense-motor, bit1 change-return timeout.
REQ-010 dur0, dur1  input  16 each  requested duration in ms, sampled at grant.
REQ-011 abort  input  1  cancel running timer (active only with macro, REQ-030).
REQ-012 gnt  output  2  one-hot, one-cycle grant pulse.
REQ-013 busy  output  1  high while timer owned.
REQ-014 done  output  1  one-cycle expiry pulse.
REQ-015 done_id  output  1  owner index of expiring timer; valid with done.

Function
REQ-016 Base counter 0..BASE_DIV-1; tick_1ms high in cycle counter equals BASE_DIV-1, counter wraps to 0 same edge.
REQ-017 First tick_1ms occurs BASE_DIV cycles after rst_n deasserts.
REQ-018 FSM counter advances only on tick_1ms; tick_fsm asserted coincident with every FSM_DIV-th tick_1ms.
REQ-019 Blink counter advances only on tick_1ms; blink toggles coincident with every BLINK_DIV-th tick_1ms.
REQ-020 No derived clocks; all outputs are enables/levels in clk domain.
REQ-021 Timer FSM states: IDLE, RUN, DONE.
REQ-022 IDLE: if any req bit high, grant one, pulse its gnt, latch its dur into 16-bit remaining, record owner, set busy next cycle; go RUN, or DONE if dur is 0.
REQ-023 Arbitration round-robin: both requesting -> grant the requester not served last; pointer updates on each grant.
REQ-024 RUN: remaining decrements on each tick_1ms; tick_1ms in the grant cycle not counted; decrement to 0 -> DONE.
REQ-025 DONE: done high one cycle, done_id = owner, busy low from next cycle, return IDLE.
REQ-026 req sampled only in IDLE; requests held while busy wait; requester drops req after gnt; req still high in IDLE re-requests.
REQ-027 Expiry occurs exactly dur tick_1ms pulses after grant; no wrap, remaining never decrements below 0.

Reset
REQ-028 rst_n low at clk edge: all counters 0, state IDLE, round-robin pointer favours req0, all outputs 0 (blink 0, busy 0, gnt 0, done 0, done_id 0).
REQ-029 Reset mid-RUN discards timer with no done pulse.

Configuration
REQ-030 Macro TICK_SCHED_ABORT_EN defined: abort high in RUN returns FSM to IDLE next edge, busy low, no done; abort coincident with final decrement wins (no done); abort outside RUN ignored.
REQ-031 Macro undefined: abort port present but ignored; every granted timer ends with done.

Verification (BASE_DIV=4, FSM_DIV=2, BLINK_DIV=3)
REQ-032 Release reset, idle 30 cycles -> tick_1ms at cycles 4,8,12..; tick_fsm at 8,16,24; blink toggles at 12,24.
REQ-033 req=01, dur0=3 -> gnt=01 one cycle, busy high, done with done_id=0 on third subsequent tick_1ms, busy low after.
REQ-034 req=11 held continuously, dur0=dur1=1 -> grants alternate 01,10,01,10.
REQ-035 req=10, dur1=0 -> gnt=10 then done, done_id=1 one cycle later, no tick_1ms needed.
REQ-036 dur0=5, abort pulsed after 2nd tick -> with TICK_SCHED_ABORT_EN busy drops next cycle, no done; without macro done after 5th tick.
REQ-037 rst_n low mid-RUN for one edge -> all outputs 0, IDLE, no done, tick counters restart from 0.
